candidategen_sequencer: RTL and testbench
=========================================

// Module: candidategen_sequencer
// PURPOSE
//  Drives candidategen_setA through a full neighbourhood sweep. For each J_index it issues
//   one start_gen per A_value that differs from the latched initial symbol.
//  Waits for each burst's candidate_row_tlast before issuing the next start; pulses sweep_done at the end.
//  Sits between the search-control FSM and the candidate generator; owns the generator's start/config inputs.
// PARAMETERS
//  J        14   vector length (symbols per row)
//  A        2    alphabet size; must be >= 2
//  TIMEOUT  4096 max cycles waiting for tlast per burst (used only with CGSEQ_TIMEOUT_EN)
//  Derived: AWIDTH=$clog2(A)+1, J_WIDTH=$clog2(J)+1
// PORTS
//  clk                 in   1          clock, all logic on rising edge
//  rst                 in   1          synchronous reset, active-high
//  x_initial           in   J*AWIDTH   initial vector, symbol j at [j*AWIDTH +: AWIDTH]
//  x_initial_tvalid    in   1          load x_initial (accepted only in IDLE)
//  sweep_start         in   1          begin sweep (accepted in IDLE when a vector is loaded)
//  sweep_abort         in   1          terminate sweep, return to IDLE
//  gen_tlast           in   1          candidate_row_tlast from generator
//  start_gen           out  1          one-cycle start pulse to generator
//  J_index             out  J_WIDTH    current symbol position; held stable between pulses
//  A_value             out  AWIDTH     current substituted value; held stable between pulses
//  busy                out  1          high from sweep accept until return to IDLE
//  sweep_done          out  1          one-cycle pulse: all bursts completed
//  burst_cnt           out  16         bursts issued in current or last sweep
//  timeout_err         out  1          sticky error flag (0 when CGSEQ_TIMEOUT_EN is undefined)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; loaded flag cleared; x_initial_reg=0.
//  State machine:
//   IDLE   Captures x_initial on x_initial_tvalid and sets loaded.
//          On sweep_start & loaded: J_index=0, A_value=0, burst_cnt=0, timeout_err=0 -> SKIP.
//          If both arrive in one cycle, the load happens and the start is ignored.
//   SKIP   If A_value == x_initial_reg[J_index] -> ADV; otherwise -> ISSUE. No output pulse.
//   ISSUE  start_gen=1 for exactly this cycle; burst_cnt+=1 -> WAIT.
//   WAIT   Waits for gen_tlast; on gen_tlast -> GAP.
//   GAP    One idle cycle so the generator can return to its IDLE -> ADV.
//   ADV    If A_value < A-1: A_value+=1.
//          Else: A_value=0 and J_index+=1.
//          If J_index==J-1 && A_value==A-1: sweep_done=1 -> IDLE. Otherwise -> SKIP.
//  Order: J_index ascending outer loop, A_value ascending inner loop. Total bursts = J*(A-1).
//  Minimum spacing between start_gen pulses: burst length + 3 cycles.
//  busy=0 only in IDLE; sweep_done is asserted in the cycle leaving ADV; busy drops the next cycle.
//  sweep_abort in any non-IDLE state: -> IDLE next cycle; no sweep_done; J_index/A_value hold.
//   If abort occurs in ISSUE, the start_gen pulse of that cycle is still emitted.
//   If abort and gen_tlast coincide, abort wins.
//  x_initial_tvalid outside IDLE: ignored; the sweep uses the vector latched at start.
//  sweep_start while busy: ignored.
//  gen_tlast outside WAIT: ignored.
//  burst_cnt saturates at 16'hFFFF; it is held after the sweep until the next sweep_start.
//  Symbol compare uses the full AWIDTH bits. Latched symbols >= A are never equal to any A_value,
//   so every A_value is issued for that position.
// CONFIGURATION
//  CGSEQ_TIMEOUT_EN defined:
//   A WAIT-cycle counter runs and is cleared on entry to WAIT.
//   Reaching TIMEOUT cycles sets timeout_err=1 (sticky until the next sweep_start).
//   The FSM then goes to IDLE with no sweep_done.
//  CGSEQ_TIMEOUT_EN undefined: no counter is built, timeout_err is tied 0, and WAIT waits indefinitely.
// TESTING
//  1. J=14,A=2, x_initial=0, sweep_start; tlast 5 cycles after each start_gen
//     -> 14 pulses, J_index 0..13, A_value=1 each; one sweep_done; burst_cnt=14.
//  2. J=4,A=3, x_initial symbols {2,0,1,2}
//     -> 8 pulses, (J,A) = (0,0),(0,1),(1,1),(1,2),(2,0),(2,2),(3,0),(3,1).
//  3. Abort during WAIT of 3rd burst -> busy=0 next cycle, no sweep_done, burst_cnt=3.
//     A new sweep_start then restarts at (0,0).
//  4. x_initial_tvalid with new data during sweep
//     -> ignored; skip pattern matches the vector loaded before start.
//  5. rst asserted mid-WAIT -> all outputs 0 next cycle; sweep_start without a reload is ignored.
//  6. CGSEQ_TIMEOUT_EN, TIMEOUT=16, gen_tlast never driven
//     -> timeout_err=1 after 16 WAIT cycles, return to IDLE, no sweep_done.
//     Without the macro: busy stays 1.

Source files
------------

// File: rtl/candidategen_sequencer.sv
// Sequences candidategen_setA through a full neighbourhood sweep, one burst per (J_index, A_value)
// that differs from the latched symbol. Optional WAIT watchdog enabled by macro CGSEQ_TIMEOUT_EN.
module candidategen_sequencer #(
    parameter int J       = 14,
    parameter int A       = 2,
    parameter int TIMEOUT = 4096,
    localparam int AWIDTH  = $clog2(A) + 1,
    localparam int J_WIDTH = $clog2(J) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [J*AWIDTH-1:0]   x_initial,
    input  logic                  x_initial_tvalid,
    input  logic                  sweep_start,
    input  logic                  sweep_abort,
    input  logic                  gen_tlast,
    output logic                  start_gen,
    output logic [J_WIDTH-1:0]    J_index,
    output logic [AWIDTH-1:0]     A_value,
    output logic                  busy,
    output logic                  sweep_done,
    output logic [15:0]           burst_cnt,
    output logic                  timeout_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SKIP  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        GAP   = 3'd4,
        ADV   = 3'd5
    } state_t;

    localparam logic [AWIDTH-1:0]  A_MAX  = AWIDTH'(A - 1);
    localparam logic [J_WIDTH-1:0] J_LAST = J_WIDTH'(J - 1);

    state_t                state_q, state_d;
    logic [J*AWIDTH-1:0]   x_initial_q, x_initial_d;
    logic                  loaded_q, loaded_d;
    logic [J_WIDTH-1:0]    j_index_q, j_index_d;
    logic [AWIDTH-1:0]     a_value_q, a_value_d;
    logic [15:0]           burst_cnt_q, burst_cnt_d;
    logic [J-1:0]          sym_match;
    logic                  cur_match;
    logic                  last_pos;

    // Full-width compare: a latched symbol >= A can never match, so all values get issued there.
    genvar gi;
    generate
        for (gi = 0; gi < J; gi++) begin : g_sym
            assign sym_match[gi] = (j_index_q == J_WIDTH'(gi)) &&
                                   (x_initial_q[gi*AWIDTH +: AWIDTH] == a_value_q);
        end
    endgenerate

    assign cur_match = |sym_match;
    assign last_pos  = (j_index_q == J_LAST) && (a_value_q == A_MAX);

`ifdef CGSEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          timeout_err_q, timeout_err_d;
    assign timeout_err = timeout_err_q;
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT);
    assign timeout_err    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        x_initial_d = x_initial_q;
        loaded_d    = loaded_q;
        j_index_d   = j_index_q;
        a_value_d   = a_value_q;
        burst_cnt_d = burst_cnt_q;
        start_gen   = 1'b0;
        sweep_done  = 1'b0;
`ifdef CGSEQ_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            IDLE: begin
                // A load in the same cycle as a start wins; the start is dropped.
                if (x_initial_tvalid) begin
                    x_initial_d = x_initial;
                    loaded_d    = 1'b1;
                end else if (sweep_start && loaded_q) begin
                    j_index_d   = '0;
                    a_value_d   = '0;
                    burst_cnt_d = '0;
`ifdef CGSEQ_TIMEOUT_EN
                    timeout_err_d = 1'b0;
`endif
                    state_d     = SKIP;
                end
            end
            SKIP: begin
                state_d = cur_match ? ADV : ISSUE;
            end
            ISSUE: begin
                start_gen = 1'b1;
                if (burst_cnt_q != 16'hFFFF) begin
                    burst_cnt_d = burst_cnt_q + 16'd1;
                end
`ifdef CGSEQ_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (gen_tlast) begin
                    state_d = GAP;
                end
`ifdef CGSEQ_TIMEOUT_EN
                else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            GAP: begin
                state_d = ADV;
            end
            ADV: begin
                if (last_pos) begin
                    sweep_done = 1'b1;
                    state_d    = IDLE;
                end else begin
                    if (a_value_q < A_MAX) begin
                        a_value_d = a_value_q + 1'b1;
                    end else begin
                        a_value_d = '0;
                        j_index_d = j_index_q + 1'b1;
                    end
                    state_d = SKIP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything except a start pulse already being emitted this cycle.
        if (sweep_abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            sweep_done = 1'b0;
            j_index_d  = j_index_q;
            a_value_d  = a_value_q;
`ifdef CGSEQ_TIMEOUT_EN
            timeout_err_d = timeout_err_q;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_initial_q <= '0;
            loaded_q    <= 1'b0;
            j_index_q   <= '0;
            a_value_q   <= '0;
            burst_cnt_q <= '0;
`ifdef CGSEQ_TIMEOUT_EN
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            x_initial_q <= x_initial_d;
            loaded_q    <= loaded_d;
            j_index_q   <= j_index_d;
            a_value_q   <= a_value_d;
            burst_cnt_q <= burst_cnt_d;
`ifdef CGSEQ_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign J_index   = j_index_q;
    assign A_value   = a_value_q;
    assign busy      = (state_q != IDLE);
    assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_candidategen_sequencer.sv
// Directed bench for candidategen_sequencer: a default instance (J=14,A=2) and a small one
// (J=4,A=3,TIMEOUT=16); start_gen pulses are checked against an expected (J,A) queue.
module tb_candidategen_sequencer;

    localparam int JA = 14, AA = 2, AWA = 2, JWA = 5;
    localparam int JB = 4,  AB = 3, AWB = 3, JWB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [JA*AWA-1:0] x_a;
    logic              xv_a, ss_a, ab_a, tl_a;
    logic              sg_a, busy_a, done_a, te_a;
    logic [JWA-1:0]    ji_a;
    logic [AWA-1:0]    av_a;
    logic [15:0]       bc_a;

    logic [JB*AWB-1:0] x_b;
    logic              xv_b, ss_b, ab_b, tl_b;
    logic              sg_b, busy_b, done_b, te_b;
    logic [JWB-1:0]    ji_b;
    logic [AWB-1:0]    av_b;
    logic [15:0]       bc_b;

    candidategen_sequencer #(.J(JA), .A(AA)) dut_a (
        .clk(clk), .rst(rst), .x_initial(x_a), .x_initial_tvalid(xv_a),
        .sweep_start(ss_a), .sweep_abort(ab_a), .gen_tlast(tl_a),
        .start_gen(sg_a), .J_index(ji_a), .A_value(av_a), .busy(busy_a),
        .sweep_done(done_a), .burst_cnt(bc_a), .timeout_err(te_a)
    );

    candidategen_sequencer #(.J(JB), .A(AB), .TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst), .x_initial(x_b), .x_initial_tvalid(xv_b),
        .sweep_start(ss_b), .sweep_abort(ab_b), .gen_tlast(tl_b),
        .start_gen(sg_b), .J_index(ji_b), .A_value(av_b), .busy(busy_b),
        .sweep_done(done_b), .burst_cnt(bc_b), .timeout_err(te_b)
    );

    int tests = 0;
    int fails = 0;
    int q_a[$];
    int q_b[$];
    int tl_cnt_a = 0, tl_cnt_b = 0;
    bit tlast_en = 1'b1;
    int done_cnt_a = 0, done_cnt_b = 0;
    int pulses_a = 0, pulses_b = 0;
    bit prev_done_a = 1'b0, prev_done_b = 1'b0;
    int lat_b[JB];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: sample after the edge, score start pulses, and model the generator's tlast.
    task automatic tick();
        int e;
        @(posedge clk);
        #1;
        if (prev_done_a) check("busy_after_done_a", 32'(busy_a), 0);
        if (prev_done_b) check("busy_after_done_b", 32'(busy_b), 0);
        prev_done_a = done_a;
        prev_done_b = done_b;
        if (done_a) done_cnt_a++;
        if (done_b) done_cnt_b++;
        if (sg_a) begin
            pulses_a++;
            check("sb_a_avail", 32'(q_a.size() != 0), 1);
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                check("pulse_a_J", 32'(ji_a), 32'(e / 256));
                check("pulse_a_A", 32'(av_a), 32'(e % 256));
                $display("[TB] A burst %0d: J=%0d A=%0d", pulses_a, ji_a, av_a);
            end
            tl_cnt_a = tlast_en ? 5 : 0;
        end else if (tl_cnt_a > 0) begin
            tl_cnt_a--;
        end
        if (sg_b) begin
            pulses_b++;
            check("sb_b_avail", 32'(q_b.size() != 0), 1);
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                check("pulse_b_J", 32'(ji_b), 32'(e / 256));
                check("pulse_b_A", 32'(av_b), 32'(e % 256));
                $display("[TB] B burst %0d: J=%0d A=%0d", pulses_b, ji_b, av_b);
            end
            tl_cnt_b = tlast_en ? 5 : 0;
        end else if (tl_cnt_b > 0) begin
            tl_cnt_b--;
        end
        tl_a = tlast_en && (tl_cnt_a == 1);
        tl_b = tlast_en && (tl_cnt_b == 1);
    endtask

    task automatic load_b(input int s0, input int s1, input int s2, input int s3, input bit accepted);
        x_b  = {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
        xv_b = 1'b1;
        tick();
        xv_b = 1'b0;
        if (accepted) begin
            lat_b[0] = s0; lat_b[1] = s1; lat_b[2] = s2; lat_b[3] = s3;
        end
    endtask

    task automatic start_b();
        for (int j = 0; j < JB; j++)
            for (int a = 0; a < AB; a++)
                if (a != lat_b[j]) q_b.push_back(j * 256 + a);
        ss_b = 1'b1;
        tick();
        ss_b = 1'b0;
    endtask

    task automatic run_idle_b(input string tag, input int budget);
        int n = 0;
        while (busy_b && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(busy_b), 0);
        tick();
    endtask

    task automatic wait_pulses_b(input string tag, input int target, input int budget);
        int n = 0;
        while (pulses_b < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(pulses_b >= target), 1);
    endtask

    task automatic flush_b();
        q_b.delete();
        tl_cnt_b = 0;
        tl_b     = 1'b0;
    endtask

    initial begin
        int n;
        int d0;
        int p0;
        rst = 1'b1;
        x_a = '0; xv_a = 0; ss_a = 0; ab_a = 0; tl_a = 0;
        x_b = '0; xv_b = 0; ss_b = 0; ab_b = 0; tl_b = 0;
        tick();
        tick();
        check("rst_a_start_gen", 32'(sg_a), 0);
        check("rst_a_busy", 32'(busy_a), 0);
        check("rst_a_burst_cnt", 32'(bc_a), 0);
        check("rst_b_J", 32'(ji_b), 0);
        check("rst_b_A", 32'(av_b), 0);
        check("rst_b_done", 32'(done_b), 0);
        check("rst_b_timeout", 32'(te_b), 0);
        rst = 1'b0;
        tick();

        // Load and start in the same cycle: only the load takes effect.
        x_b = {3'd2, 3'd1, 3'd0, 3'd2};
        xv_b = 1'b1; ss_b = 1'b1;
        tick();
        xv_b = 1'b0; ss_b = 1'b0;
        lat_b[0] = 2; lat_b[1] = 0; lat_b[2] = 1; lat_b[3] = 2;
        tick();
        check("load_start_same_cycle_busy", 32'(busy_b), 0);

        // Test 1: default J=14, A=2, all-zero vector.
        x_a = '0; xv_a = 1'b1;
        tick();
        xv_a = 1'b0;
        for (int j = 0; j < JA; j++) q_a.push_back(j * 256 + 1);
        ss_a = 1'b1;
        tick();
        ss_a = 1'b0;
        check("t1_busy_after_start", 32'(busy_a), 1);
        n = 0;
        while (busy_a && n < 2000) begin
            tick();
            n++;
        end
        check("t1_idle_in_budget", 32'(busy_a), 0);
        tick();
        check("t1_pulses", 32'(pulses_a), 14);
        check("t1_done_count", 32'(done_cnt_a), 1);
        check("t1_burst_cnt", 32'(bc_a), 14);
        check("t1_queue_empty", 32'(q_a.size()), 0);

        // Test 2: J=4, A=3, vector {2,0,1,2}.
        start_b();
        run_idle_b("t2_idle_in_budget", 500);
        check("t2_done_count", 32'(done_cnt_b), 1);
        check("t2_burst_cnt", 32'(bc_b), 8);
        check("t2_queue_empty", 32'(q_b.size()), 0);

        // Test 3: abort during WAIT of the third burst, then restart.
        d0 = done_cnt_b;
        p0 = pulses_b;
        start_b();
        wait_pulses_b("t3_third_pulse", p0 + 3, 200);
        tick();
        ab_b = 1'b1;
        tick();
        ab_b = 1'b0;
        check("t3_busy_after_abort", 32'(busy_b), 0);
        check("t3_burst_cnt", 32'(bc_b), 3);
        check("t3_J_hold", 32'(ji_b), 1);
        check("t3_A_hold", 32'(av_b), 1);
        flush_b();
        tick();
        tick();
        check("t3_no_done", 32'(done_cnt_b), 32'(d0));
        start_b();
        run_idle_b("t3_restart_idle", 500);
        check("t3_restart_done", 32'(done_cnt_b), 32'(d0 + 1));
        check("t3_restart_burst_cnt", 32'(bc_b), 8);
        check("t3_restart_queue_empty", 32'(q_b.size()), 0);

        // Test 4: out-of-range symbols, and a reload attempted mid-sweep.
        load_b(3, 1, 5, 0, 1'b1);
        start_b();
        tick();
        tick();
        load_b(0, 0, 0, 0, 1'b0);
        run_idle_b("t4_idle_in_budget", 800);
        check("t4_burst_cnt", 32'(bc_b), 10);
        check("t4_queue_empty", 32'(q_b.size()), 0);

        // Test 5: reset mid-WAIT clears everything, including the loaded flag.
        p0 = pulses_b;
        start_b();
        wait_pulses_b("t5_first_pulse", p0 + 1, 100);
        tick();
        rst = 1'b1;
        tick();
        check("t5_rst_start_gen", 32'(sg_b), 0);
        check("t5_rst_busy", 32'(busy_b), 0);
        check("t5_rst_J", 32'(ji_b), 0);
        check("t5_rst_A", 32'(av_b), 0);
        check("t5_rst_burst_cnt", 32'(bc_b), 0);
        check("t5_rst_done", 32'(done_b), 0);
        rst = 1'b0;
        flush_b();
        ss_b = 1'b1;
        tick();
        ss_b = 1'b0;
        tick();
        check("t5_start_without_load", 32'(busy_b), 0);

        // Test 6: generator never returns tlast.
        load_b(1, 1, 1, 1, 1'b1);
        tlast_en = 1'b0;
        d0 = done_cnt_b;
        p0 = pulses_b;
        start_b();
        wait_pulses_b("t6_first_pulse", p0 + 1, 100);
        repeat (16) tick();
        check("t6_busy_at_16", 32'(busy_b), 1);
        tick();
`ifdef CGSEQ_TIMEOUT_EN
        check("t6_busy_after_timeout", 32'(busy_b), 0);
        check("t6_timeout_err", 32'(te_b), 1);
`else
        check("t6_busy_no_timeout", 32'(busy_b), 1);
        check("t6_timeout_err_tied", 32'(te_b), 0);
        ab_b = 1'b1;
        tick();
        ab_b = 1'b0;
`endif
        tick();
        check("t6_no_done", 32'(done_cnt_b), 32'(d0));
        check("t6_idle_at_end", 32'(busy_b), 0);
        flush_b();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
